// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters
module alu_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_OP_BITS = 4,
  parameter int ALU_OP_CMP  = 13,
  parameter int ALU_OP_TEST = 14,
  parameter int ALU_OP_NOP  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [ALU_OP_BITS-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]  req0_a,
  input  logic [DATA_WIDTH-1:0]  req0_b,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [ALU_OP_BITS-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]  req1_a,
  input  logic [DATA_WIDTH-1:0]  req1_b,
  output logic [ALU_OP_BITS-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]  alu_data1,
  output logic [DATA_WIDTH-1:0]  alu_data2,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_less,
  input  logic                   alu_greater,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [DATA_WIDTH-1:0]  rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_less,
  output logic                   rsp_greater
);
  localparam logic [ALU_OP_BITS-1:0] NOP  = ALU_OP_BITS'(ALU_OP_NOP);
  localparam logic [ALU_OP_BITS-1:0] CMP  = ALU_OP_BITS'(ALU_OP_CMP);
  localparam logic [ALU_OP_BITS-1:0] TEST = ALU_OP_BITS'(ALU_OP_TEST);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t                 state_q;
  logic                   prio_q, id_q, z_q, l_q, g_q;
  logic [ALU_OP_BITS-1:0] op_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q, res_q;
  logic                   acc, gnt, exec;
  always_comb begin
    acc  = ~reset & (state_q == IDLE) & (req0_valid | req1_valid);
    // prio_q names the requester that wins a tie
    gnt  = req1_valid & (~req0_valid | prio_q);
    exec = state_q == EXEC;
  end
  assign req0_ready  = acc & ~gnt;
  assign req1_ready  = acc & gnt;
  assign alu_op      = exec ? op_q : NOP;
  assign alu_data1   = exec ? a_q : '0;
  assign alu_data2   = exec ? b_q : '0;
  assign rsp_valid   = state_q == RESP;
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_zero    = z_q;
  assign rsp_less    = l_q;
  assign rsp_greater = g_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (acc) begin
          op_q    <= gnt ? req1_op : req0_op;
          a_q     <= gnt ? req1_a : req0_a;
          b_q     <= gnt ? req1_b : req0_b;
          id_q    <= gnt;
          prio_q  <= ~gnt;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q <= alu_result;
          if (op_q == CMP || op_q == TEST) {z_q, l_q, g_q} <= {alu_zero, alu_less, alu_greater};
          state_q <= RESP;
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and random traffic vs a transaction model
module tb_alu_arbiter;
  localparam logic [3:0] NOP = 4'd15, CMP = 4'd13, TST = 4'd14;
  logic clk = 0, reset = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_less, rsp_greater;
  logic [3:0] req0_op = 0, req1_op = 0, alu_op;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [31:0] alu_data1, alu_data2, alu_result, rsp_result;
  logic alu_zero, alu_less, alu_greater;
  int nchk = 0, nerr = 0;
  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less), .alu_greater(alu_greater),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_less(rsp_less), .rsp_greater(rsp_greater)
  );

  function automatic logic [34:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = op == 0 ? a + b : op == 1 ? a - b : op == 2 ? a & b : op == 3 ? a | b :
        op == 4 ? a ^ b : op == CMP ? a - b : op == TST ? a & b : 32'd0;
    return {r, r == 0, op == CMP && a < b, op == CMP && a > b};
  endfunction

  always_comb {alu_result, alu_zero, alu_less, alu_greater} = alu_f(alu_op, alu_data1, alu_data2);

  // transaction model: one op in flight, m_age counts cycles since acceptance
  bit m_busy, m_prio, m_id, m_acc0, m_acc1, d_r0, d_r1;
  int m_age;
  logic [3:0] m_op;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0] m_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_prio = 0; m_id = 0; m_age = 0; m_acc0 = 0; m_acc1 = 0;
    m_op = NOP; m_a = 0; m_b = 0; m_res = 0; m_f = 0;
  endtask

  task automatic cycle();
    bit g0, g1, ex, rv;
    logic [34:0] o;
    #1;
    g0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
    g1 = !m_busy && req1_valid && (!req0_valid || m_prio);
    ex = m_busy && m_age == 1;
    rv = m_busy && m_age == 2;
    d_r0 = req0_ready; d_r1 = req1_ready;
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("alu_op", alu_op, ex ? m_op : NOP);
    chk("alu_data1", alu_data1, ex ? m_a : 0);
    chk("alu_data2", alu_data2, ex ? m_b : 0);
    chk("rsp_valid", rsp_valid, rv);
    if (rv) chk("rsp_id", rsp_id, m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_flags", {rsp_zero, rsp_less, rsp_greater}, m_f);
    m_acc0 = g0; m_acc1 = g1;
    if (g0 || g1) begin
      m_busy = 1; m_age = 1; m_id = g1; m_prio = !g1;
      m_op = g1 ? req1_op : req0_op;
      m_a = g1 ? req1_a : req0_a;
      m_b = g1 ? req1_b : req0_b;
    end else if (ex) begin
      o = alu_f(m_op, m_a, m_b);
      m_res = o[34:3];
      if (m_op == CMP || m_op == TST) m_f = o[2:0];
      m_age = 2;
    end else if (rv && rsp_ready) m_busy = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    model_reset();
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_alu_op", alu_op, NOP);
    chk("rst_rsp", {rsp_id, rsp_result, rsp_zero, rsp_less, rsp_greater}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic idle_cycles(input int n);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (n) cycle();
  endtask

  typedef struct {bit id; logic [3:0] op; logic [31:0] a, b, res; logic [2:0] f;} vec_t;
  vec_t tbl[10];

  task automatic send(input vec_t v);
    int n;
    rsp_ready = 1;
    req0_valid = !v.id; req1_valid = v.id;
    if (v.id) begin req1_op = v.op; req1_a = v.a; req1_b = v.b; end
    else begin req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    n = 0;
    do begin cycle(); n++; end while (!(m_acc0 || m_acc1) && n < 8);
    req0_valid = 0; req1_valid = 0;
    cycle();
    #1;
    chk("vec_valid", rsp_valid, 1);
    chk("vec_id", rsp_id, v.id);
    chk("vec_result", rsp_result, v.res);
    chk("vec_flags", {rsp_zero, rsp_less, rsp_greater}, v.f);
    cycle();
  endtask

  initial begin
    int gl[$], gt[$];
    vec_t v;
    tbl[0] = '{0, 4'd0, 5, 7, 12, 3'b000};
    tbl[1] = '{1, CMP, 3, 3, 0, 3'b100};
    tbl[2] = '{1, 4'd0, 1, 1, 2, 3'b100};
    tbl[3] = '{0, CMP, 2, 5, 32'hFFFFFFFD, 3'b010};
    tbl[4] = '{0, 4'd1, 5, 5, 0, 3'b010};
    tbl[5] = '{1, TST, 32'hF0, 32'h0F, 0, 3'b100};
    tbl[6] = '{0, 4'd4, 32'hFF, 32'h0F, 32'hF0, 3'b100};
    tbl[7] = '{1, CMP, 9, 4, 5, 3'b001};
    tbl[8] = '{0, 4'd2, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 3'b001};
    tbl[9] = '{1, 4'd3, 0, 0, 0, 3'b001};
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 10; i++) send(tbl[i]);
    idle_cycles(2);

    do_reset();
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    req0_op = 0; req0_a = 10; req0_b = 20; req1_op = 1; req1_a = 50; req1_b = 8;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (d_r0 || d_r1) begin gl.push_back(d_r1 ? 1 : 0); gt.push_back(c); end
    end
    chk("contention_count", gl.size(), 4);
    for (int k = 0; k < gl.size(); k++) begin
      chk("contention_grant", gl[k], k % 2);
      chk("contention_time", gt[k], 3 * k);
    end
    idle_cycles(3);

    req0_valid = 1; req0_op = 0; req0_a = 9; req0_b = 9; rsp_ready = 0;
    for (int n = 0; n < 6 && !(m_busy && m_age == 2); n++) cycle();
    req1_valid = 1;
    repeat (5) cycle();
    chk("bp_held_result", rsp_result, 18);
    rsp_ready = 1;
    cycle();
    idle_cycles(4);

    do_reset();
    send('{1, CMP, 3, 3, 0, 3'b100});
    send('{0, 4'd0, 5, 7, 12, 3'b100});
    req0_valid = 1; req0_op = 0; req0_a = 1; req0_b = 2; rsp_ready = 1;
    cycle();
    chk("pre_reset_exec", alu_op, 0);
    #1 reset = 1; req1_valid = 1;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", {req0_ready, req1_ready}, 0);
    chk("mid_rst_alu", {alu_op, alu_data1, alu_data2}, {NOP, 64'd0});
    chk("mid_rst_rsp", {rsp_id, rsp_result, rsp_zero, rsp_less, rsp_greater}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    cycle();
    chk("post_reset_grant", {d_r1, d_r0}, 2'b01);
    idle_cycles(4);

    for (int c = 0; c < 400; c++) begin
      req0_valid = $urandom_range(0, 1); req1_valid = $urandom_range(0, 1);
      rsp_ready = $urandom_range(0, 9) < 7;
      req0_op = $urandom_range(0, 6); req1_op = $urandom_range(0, 6);
      if (req0_op > 4) req0_op = req0_op + 8;
      if (req1_op > 4) req1_op = req1_op + 8;
      req0_a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req0_b = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req1_a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      req1_b = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      cycle();
    end
    idle_cycles(4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter ALU_OP_BITS, default 4, opcode width.
REQ-003 Parameters ALU_OP_CMP and ALU_OP_TEST, defaults 13 and 14: flag-producing opcodes.
REQ-004 Parameter ALU_OP_NOP, default 15, opcode driven when the ALU is unused.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-008 reqN_ready  output  1  (N=0,1) operation of requester N accepted this cycle.
REQ-009 reqN_op / reqN_a / reqN_b  input  ALU_OP_BITS / DATA_WIDTH / DATA_WIDTH  opcode and operands.
REQ-010 alu_op / alu_data1 / alu_data2  output  ALU_OP_BITS / DATA_WIDTH / DATA_WIDTH  drive to the shared combinational ALU.
REQ-011 alu_result / alu_zero / alu_less / alu_greater  input  DATA_WIDTH / 1 / 1 / 1  ALU outputs, valid in the same cycle as the drive.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_id  output  1  requester index the response belongs to.
REQ-015 rsp_result / rsp_zero / rsp_less / rsp_greater  output  DATA_WIDTH / 1 / 1 / 1  registered result and flags.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-017 In IDLE, if any reqN_valid is high, the block SHALL assert exactly one reqN_ready combinationally, latch that op/operands and grant id, and go to EXEC at the edge.
REQ-018 When both requesters are valid, the grant SHALL go to the requester not granted most recently; the round-robin pointer after reset SHALL favour requester 0.
REQ-019 The round-robin pointer SHALL update only on an accepted grant.
REQ-020 reqN_ready SHALL be low in EXEC and RESP, and low in IDLE when reqN_valid is low.
REQ-021 In EXEC, alu_op/alu_data1/alu_data2 SHALL carry the latched request; in all other states alu_op SHALL be ALU_OP_NOP and the data outputs zero.
REQ-022 At the end of EXEC, rsp_result SHALL capture alu_result and the FSM SHALL go to RESP.
REQ-023 rsp_zero/less/greater SHALL capture the ALU flags only when the executed op is ALU_OP_CMP or ALU_OP_TEST; otherwise they SHALL hold their previous values (sticky flags).
REQ-024 For CMP/TEST, rsp_result SHALL still capture alu_result (content not relied upon).
REQ-025 rsp_valid SHALL be high exactly in RESP; rsp_id and rsp_* SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-026 In RESP with rsp_ready high, the FSM SHALL return to IDLE at the edge; a new grant is possible no earlier than the following cycle (no bypass from RESP).
REQ-027 Latency: request accepted at edge N, rsp_valid high from edge N+2; minimum issue interval 3 cycles.
REQ-028 The block SHALL hold no more than one operation in flight.

Reset
REQ-029 On reset assertion, state SHALL immediately become IDLE, rsp_valid 0, reqN_ready 0, rsp_result 0, rsp_zero/less/greater 0, rsp_id 0, pointer favouring requester 0, alu_op ALU_OP_NOP.
REQ-030 Reset asserted during EXEC or RESP SHALL discard the in-flight operation without producing a response.

Verification
REQ-031 Single request: req0 ADD a=5 b=7 at edge 0 -> req0_ready high in cycle 0, alu_op=ADD in cycle 1, rsp_valid=1 rsp_id=0 rsp_result=12 from edge 2.
REQ-032 Contention: both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1, one every 3 cycles.
REQ-033 Flags: req1 CMP a=3 b=3 -> rsp_zero=1; then req1 ADD 1+1 -> rsp_result=2 and rsp_zero still 1.
REQ-034 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_* stable, both reqN_ready low, alu_op=NOP throughout.
REQ-035 Reset mid-EXEC: assert reset in EXEC -> rsp_valid never rises, all outputs at reset values asynchronously, next request after release granted to requester 0.
